clk_wiz_supervisor: RTL and testbench

- Power-up and lock supervisor for the clk_wiz_0 clocking wizard instance.
- Runs in the free-running input clock domain (clk_in1) and drives the wizard's reset input.
- Waits for a stable `locked`, then releases a downstream reset.
- Handles lock timeout with bounded retries, restarts the wizard on loss of lock, and reports status to the top level.

---
 rtl/clk_wiz_supervisor.sv | 88 ++++++++
 tb/tb_clk_wiz_supervisor.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/clk_wiz_supervisor.sv
// clk_wiz_supervisor: power-up/lock supervisor for clk_wiz_0 (ports: clk_in1, reset, locked, restart -> mmcm_reset, rst_out, ready, fail, lock_lost, retry_cnt, state)
module clk_wiz_supervisor #(
  parameter int RST_HOLD_CYCLES    = 16,
  parameter int LOCK_TIMEOUT       = 1000,
  parameter int LOCK_STABLE_CYCLES = 64,
  parameter int MAX_RETRIES        = 3
) (
  input  logic       clk_in1,
  input  logic       reset,
  input  logic       locked,
  input  logic       restart,
  output logic       mmcm_reset,
  output logic       rst_out,
  output logic       ready,
  output logic       fail,
  output logic       lock_lost,
  output logic [3:0] retry_cnt,
  output logic [2:0] state
);
  localparam int MAX_AB = RST_HOLD_CYCLES > LOCK_TIMEOUT ? RST_HOLD_CYCLES : LOCK_TIMEOUT;
  localparam int MAX_P  = MAX_AB > LOCK_STABLE_CYCLES ? MAX_AB : LOCK_STABLE_CYCLES;
  localparam int CW     = $clog2(MAX_P) + 1;
  localparam logic [2:0] HOLD = 3'd0, WAIT_LOCK = 3'd1, STABLE = 3'd2, RUN = 3'd3, FAIL = 3'd4;
  logic [1:0]    sync;
  logic          locked_s;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0]    state_n;
  logic [3:0]    retry_n;
  logic          lost_n;
  assign locked_s = sync[1];
  always_comb begin
    state_n = state;
    retry_n = retry_cnt;
    lost_n  = lock_lost;
    if (restart) begin
      state_n = HOLD;
      retry_n = '0;
      lost_n  = 1'b0;
    end else begin
      case (state)
        HOLD:      state_n = cnt == CW'(RST_HOLD_CYCLES - 1) ? WAIT_LOCK : HOLD;
        WAIT_LOCK: begin
          if (locked_s) state_n = STABLE;
          else if (cnt == CW'(LOCK_TIMEOUT - 1)) begin
            retry_n = retry_cnt + 4'd1;
            state_n = retry_n == 4'(MAX_RETRIES) ? FAIL : HOLD;
          end
        end
        STABLE: begin
          if (!locked_s) state_n = WAIT_LOCK;
          else if (cnt == CW'(LOCK_STABLE_CYCLES - 1)) begin
            state_n = RUN;
            retry_n = '0;
          end
        end
        RUN: begin
          if (!locked_s) begin
            state_n = HOLD;
            lost_n  = 1'b1;
          end
        end
        FAIL:    state_n = FAIL;
        default: state_n = HOLD;
      endcase
    end
    // RUN and FAIL have no timed exit, so the counter parks at zero there
    cnt_n = (restart || state_n != state || state == RUN || state == FAIL) ? '0 : cnt + CW'(1);
  end
  always_ff @(posedge clk_in1 or posedge reset) begin
    if (reset) begin
      sync      <= '0;
      cnt       <= '0;
      state     <= HOLD;
      retry_cnt <= '0;
      lock_lost <= 1'b0;
    end else begin
      sync      <= {sync[0], locked};
      cnt       <= cnt_n;
      state     <= state_n;
      retry_cnt <= retry_n;
      lock_lost <= lost_n;
    end
  end
  assign mmcm_reset = state == HOLD || state == FAIL;
  assign rst_out    = state != RUN;
  assign ready      = state == RUN;
  assign fail       = state == FAIL;
endmodule

// File: tb/tb_clk_wiz_supervisor.sv
// tb_clk_wiz_supervisor: directed plus randomized check of clk_wiz_supervisor against a timestamp-based phase model
module tb_clk_wiz_supervisor;
  localparam int HC = 4, TO = 20, SC = 8, MR = 2;
  localparam logic [11:0] RSTV = {3'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0};
  logic       clk_in1 = 1'b0, reset = 1'b1, locked = 1'b0, restart = 1'b0;
  logic       mmcm_reset, rst_out, ready, fail, lock_lost;
  logic [3:0] retry_cnt;
  logic [2:0] state;
  int total = 0, bad = 0;
  int ph = 0, rc = 0, cyc = 0, t0 = 0;
  bit lost = 0, h0 = 0, h1 = 0;
  clk_wiz_supervisor #(
    .RST_HOLD_CYCLES(HC), .LOCK_TIMEOUT(TO), .LOCK_STABLE_CYCLES(SC), .MAX_RETRIES(MR)
  ) dut (
    .clk_in1(clk_in1), .reset(reset), .locked(locked), .restart(restart),
    .mmcm_reset(mmcm_reset), .rst_out(rst_out), .ready(ready), .fail(fail),
    .lock_lost(lock_lost), .retry_cnt(retry_cnt), .state(state)
  );
  always #5 clk_in1 = ~clk_in1;
  function automatic logic [11:0] dut_vec();
    return {state, mmcm_reset, rst_out, ready, fail, lock_lost, retry_cnt};
  endfunction
  function automatic logic [11:0] model_vec();
    return {3'(ph), ph == 0 || ph == 4, ph != 3, ph == 3, ph == 4, lost, 4'(rc)};
  endfunction
  task automatic chk(input string tag, input logic [11:0] got, input logic [11:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic model_reset();
    ph = 0; rc = 0; lost = 0; h0 = 0; h1 = 0; t0 = cyc;
  endtask
  task automatic go(input int p);
    ph = p;
    t0 = cyc + 1;
  endtask
  // phase model: time-in-phase is measured from the edge the phase was entered
  task automatic step();
    int  e;
    bit  ls;
    e  = cyc - t0;
    ls = h1;
    h1 = h0;
    h0 = locked;
    if (restart) begin
      rc = 0; lost = 0; go(0);
    end else if (ph == 0) begin
      if (e + 1 >= HC) go(1);
    end else if (ph == 1) begin
      if (ls) go(2);
      else if (e + 1 >= TO) begin
        rc++;
        go(rc >= MR ? 4 : 0);
      end
    end else if (ph == 2) begin
      if (!ls) go(1);
      else if (e + 1 >= SC) begin
        rc = 0; go(3);
      end
    end else if (ph == 3 && !ls) begin
      lost = 1; go(0);
    end
    cyc++;
  endtask
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk_in1);
      step();
      #1;
      chk("cycle", dut_vec(), model_vec());
    end
  endtask
  task automatic pulse_restart();
    restart = 1'b1;
    tick(1);
    restart = 1'b0;
  endtask
  task automatic async_reset(input string tag);
    #2 reset = 1'b1;
    #1 chk(tag, dut_vec(), RSTV);
    #1 reset = 1'b0;
    model_reset();
  endtask
  initial begin
    repeat (2) @(posedge clk_in1);
    #1 chk("por", dut_vec(), RSTV);
    @(negedge clk_in1) reset = 1'b0;
    model_reset();
    tick(3);
    chk("t1_hold_mmcm", 12'(mmcm_reset), 12'd1);
    tick(1);
    chk("t1_wait", 12'(state), 12'd1);
    tick(3);
    locked = 1'b1;
    tick(10);
    chk("t1_stable", 12'(state), 12'd2);
    tick(1);
    chk("t1_run", {state, rst_out, ready, 4'd0, retry_cnt}, {3'd3, 1'b0, 1'b1, 4'd0, 4'd0});
    locked = 1'b0;
    pulse_restart();
    tick(24);
    chk("t2_retry", {4'd0, retry_cnt, 1'b0, state}, {4'd0, 4'd1, 1'b0, 3'd0});
    locked = 1'b1;
    tick(30);
    chk("t2_run", {4'd0, retry_cnt, 1'b0, state}, {4'd0, 4'd0, 1'b0, 3'd3});
    locked = 1'b0;
    pulse_restart();
    tick(48);
    chk("t3_fail", dut_vec(), {3'd4, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 4'd2});
    tick(100);
    chk("t3_fail_held", 12'(state), 12'd4);
    pulse_restart();
    chk("t3_restart", {state, fail, 4'd0, retry_cnt}, {3'd0, 1'b0, 4'd0, 4'd0});
    locked = 1'b1;
    tick(30);
    locked = 1'b0;
    tick(3);
    chk("t4_lost", {state, lock_lost, rst_out, ready, 5'd0}, {3'd0, 1'b1, 1'b1, 1'b0, 5'd0});
    locked = 1'b1;
    tick(30);
    chk("t4_rerun", {state, lock_lost, 8'd0}, {3'd3, 1'b1, 8'd0});
    pulse_restart();
    tick(10);
    locked = 1'b0;
    tick(1);
    locked = 1'b1;
    tick(2);
    chk("t5_wait", 12'(state), 12'd1);
    tick(1);
    chk("t5_stable", 12'(state), 12'd2);
    tick(7);
    chk("t5_not_yet", 12'(state), 12'd2);
    tick(1);
    chk("t5_run", {state, lock_lost, retry_cnt, 4'd0}, {3'd3, 1'b0, 4'd0, 4'd0});
    pulse_restart();
    tick(6);
    async_reset("t6_reset_stable");
    tick(3);
    chk("t6_hold", 12'(state), 12'd0);
    tick(1);
    chk("t6_wait", 12'(state), 12'd1);
    tick(15);
    async_reset("t6_reset_run");
    tick(4);
    chk("t6_wait2", 12'(state), 12'd1);
    for (int ep = 0; ep < 6; ep++) begin
      int rate;
      rate = ep % 3 == 0 ? 4 : ep % 3 == 1 ? 16 : 64;
      for (int i = 0; i < 300; i++) begin
        if ($urandom_range(0, rate - 1) == 0) locked = ~locked;
        restart = $urandom_range(0, 199) == 0;
        tick(1);
      end
      restart = 1'b0;
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
